mem_arbiter: RTL and testbench

//  Shares the single pipelined main memory between the I-cache fill path, the D-cache fill

---
 rtl/mem_arbiter_pkg.sv | 32 +++
 rtl/mem_arbiter_block_counter.sv | 27 ++
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the main-memory arbiter.
// Contents: address/data/offset widths, block geometry, arbiter state
// encoding, the latched store payload and the fill address builder.
package mem_arbiter_pkg;

   localparam int unsigned ADDR_W    = 16;
   localparam int unsigned DATA_W    = 16;
   localparam int unsigned OFF_W     = 3;
   localparam int unsigned BLK_WORDS = 2 ** OFF_W;
   localparam int unsigned CNT_W     = OFF_W + 1;
   localparam int unsigned BASE_W    = ADDR_W - OFF_W - 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STORE  = 2'd1,
      ST_FILL_I = 2'd2,
      ST_FILL_D = 2'd3
   } state_t;

   // Write-through store captured at grant
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } st_req_t;

   // Byte address of word idx inside the block at base
   function automatic logic [ADDR_W-1:0] fill_addr(input logic [BASE_W-1:0] base,
                                                   input logic [OFF_W-1:0]  idx);
      return {base, idx, 1'b0};
   endfunction

endpackage

// File: rtl/mem_arbiter_block_counter.sv
// Block word counter: counts 0..2**(W-1) and holds there.
// Ports: clk, rst (async active-low), clr (sync clear, wins over en),
//        en (count enable), cnt (current count).
module mem_arbiter_block_counter #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt
);

   localparam logic [W-1:0] MAX = W'(2 ** (W - 1));

   // Saturating counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != MAX)) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates main memory between I-cache fills, D-cache fills and D-cache
// write-through stores. One grant per transaction, held to completion.
// Ports: clk, rst (async active-low); i_miss/i_addr, d_miss/d_addr,
//        d_st_req/d_st_addr/d_st_data (client requests); mem_valid (read
//        return); mem_en/mem_wr/mem_addr/mem_wdata (memory command);
//        i_busy/d_busy (stalls); x_wr_data/x_wr_tag/x_off (cache fill
//        writes); d_st_done (store issued pulse).
module mem_arbiter
   import mem_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_miss,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              d_miss,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic              d_st_req,
   input  logic [ADDR_W-1:0] d_st_addr,
   input  logic [DATA_W-1:0] d_st_data,
   input  logic              mem_valid,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              i_busy,
   output logic              d_busy,
   output logic              i_wr_data,
   output logic              d_wr_data,
   output logic              i_wr_tag,
   output logic              d_wr_tag,
   output logic [OFF_W-1:0]  i_off,
   output logic [OFF_W-1:0]  d_off,
   output logic              d_st_done
);

   state_t            state, state_nxt;
   logic [BASE_W-1:0] base_q;
   st_req_t           st_q;
   logic [CNT_W-1:0]  req_cnt, rcv_cnt;
   logic              filling, req_en, rcv_en, last_rcv;
   logic              unused_addr_bits;

   // Word offset within a block is supplied by the request counter
   assign unused_addr_bits = ^{i_addr[OFF_W:0], d_addr[OFF_W:0]};

   assign filling  = (state == ST_FILL_I) || (state == ST_FILL_D);
   assign req_en   = filling && (req_cnt < CNT_W'(BLK_WORDS));
   assign rcv_en   = filling && mem_valid;
   assign last_rcv = (rcv_cnt == CNT_W'(BLK_WORDS - 1));

   // Counters idle at zero whenever no fill is active
   mem_arbiter_block_counter #(.W(CNT_W)) u_req_cnt (
      .clk (clk),
      .rst (rst),
      .clr (!filling),
      .en  (req_en),
      .cnt (req_cnt)
   );

   mem_arbiter_block_counter #(.W(CNT_W)) u_rcv_cnt (
      .clk (clk),
      .rst (rst),
      .clr (!filling),
      .en  (rcv_en),
      .cnt (rcv_cnt)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: fixed priority store > D fill > I fill, no preemption
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (d_st_req) begin
               state_nxt = ST_STORE;
            end else if (d_miss) begin
               state_nxt = ST_FILL_D;
            end else if (i_miss) begin
               state_nxt = ST_FILL_I;
            end
         end
         ST_STORE: state_nxt = ST_IDLE;
         ST_FILL_I,
         ST_FILL_D: begin
            if (mem_valid && last_rcv) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Capture the granted request so clients may change inputs afterwards
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         base_q <= '0;
         st_q   <= '0;
      end else if (state == ST_IDLE) begin
         if (d_st_req) begin
            st_q.addr <= d_st_addr;
            st_q.data <= d_st_data;
         end else if (d_miss) begin
            base_q <= d_addr[ADDR_W-1:OFF_W+1];
         end else if (i_miss) begin
            base_q <= i_addr[ADDR_W-1:OFF_W+1];
         end
      end
   end

   // Outputs; busy is gated by reset so everything reads 0 while held
   always_comb begin
      mem_en    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      i_wr_data = 1'b0;
      d_wr_data = 1'b0;
      i_wr_tag  = 1'b0;
      d_wr_tag  = 1'b0;
      i_off     = '0;
      d_off     = '0;
      d_st_done = 1'b0;
      i_busy    = rst && ((state == ST_FILL_I) || i_miss);
      d_busy    = rst && ((state == ST_STORE) || (state == ST_FILL_D) || d_miss || d_st_req);
      case (state)
         ST_STORE: begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = st_q.addr;
            mem_wdata = st_q.data;
            d_st_done = 1'b1;
         end
         ST_FILL_I: begin
            mem_en    = req_en;
            if (req_en) begin
               mem_addr = fill_addr(base_q, req_cnt[OFF_W-1:0]);
            end
            i_wr_data = mem_valid;
            i_wr_tag  = mem_valid && last_rcv;
            i_off     = rcv_cnt[OFF_W-1:0];
         end
         ST_FILL_D: begin
            mem_en    = req_en;
            if (req_en) begin
               mem_addr = fill_addr(base_q, req_cnt[OFF_W-1:0]);
            end
            d_wr_data = mem_valid;
            d_wr_tag  = mem_valid && last_rcv;
            d_off     = rcv_cnt[OFF_W-1:0];
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a 3-cycle in-order
// memory read model.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              i_miss, d_miss, d_st_req, mem_valid;
   logic [15:0]       i_addr, d_addr, d_st_addr, d_st_data;
   logic              mem_en, mem_wr, i_busy, d_busy;
   logic [15:0]       mem_addr, mem_wdata;
   logic              i_wr_data, d_wr_data, i_wr_tag, d_wr_tag, d_st_done;
   logic [2:0]        i_off, d_off;

   logic [2:0]        pipe = 3'b000;
   logic              inj = 1'b0;
   int                checks = 0;
   int                failures = 0;

   always #5 clk = ~clk;

   // Fixed-latency memory: read issued in cycle k returns in cycle k+3
   always @(posedge clk) pipe <= {pipe[1:0], mem_en & ~mem_wr};
   assign mem_valid = pipe[2] | inj;

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .i_miss(i_miss), .i_addr(i_addr),
      .d_miss(d_miss), .d_addr(d_addr),
      .d_st_req(d_st_req), .d_st_addr(d_st_addr), .d_st_data(d_st_data),
      .mem_valid(mem_valid),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .i_busy(i_busy), .d_busy(d_busy),
      .i_wr_data(i_wr_data), .d_wr_data(d_wr_data),
      .i_wr_tag(i_wr_tag), .d_wr_tag(d_wr_tag),
      .i_off(i_off), .d_off(d_off),
      .d_st_done(d_st_done)
   );

   // Follows one fill to its tag write; optionally raises a store at cycle store_at
   task automatic watch_fill(input bit is_d, input logic [15:0] addr,
                             input int exp_first, input int store_at);
      int cyc, issued, rcvd, first, last;
      bit done;
      logic wd, wt, ob, ow;
      logic [2:0] off;
      logic [15:0] exp_a;
      cyc = 0; issued = 0; rcvd = 0; first = -1; last = -1; done = 1'b0;
      while (!done && cyc < 60) begin
         @(negedge clk);
         cyc++;
         wd  = is_d ? d_wr_data : i_wr_data;
         wt  = is_d ? d_wr_tag  : i_wr_tag;
         off = is_d ? d_off     : i_off;
         ob  = is_d ? d_busy    : i_busy;
         ow  = is_d ? (i_wr_data | i_wr_tag) : (d_wr_data | d_wr_tag);
         checks++;
         if (ob !== 1'b1) begin
            failures++;
            $display("FAIL fill_busy d=%0d cyc=%0d: got %b exp 1", is_d, cyc, ob);
         end
         checks++;
         if (ow !== 1'b0) begin
            failures++;
            $display("FAIL fill_cross d=%0d cyc=%0d: other client write %b exp 0", is_d, cyc, ow);
         end
         if (mem_en === 1'b1) begin
            exp_a = (addr & 16'hFFF0) | 16'(issued * 2);
            checks++;
            if (mem_wr !== 1'b0 || mem_addr !== exp_a || issued >= 8 ||
                (last >= 0 && cyc != last + 1)) begin
               failures++;
               $display("FAIL fill_issue d=%0d n=%0d: got wr=%b addr=%h exp wr=0 addr=%h consecutive",
                        is_d, issued, mem_wr, mem_addr, exp_a);
            end
            if (first < 0) first = cyc;
            last = cyc;
            issued++;
         end
         if (wd === 1'b1) begin
            checks++;
            if (off !== 3'(rcvd)) begin
               failures++;
               $display("FAIL fill_off d=%0d: got %0d exp %0d", is_d, off, rcvd);
            end
            rcvd++;
         end
         if (wt === 1'b1) begin
            checks++;
            if (rcvd != 8 || wd !== 1'b1) begin
               failures++;
               $display("FAIL fill_tag d=%0d: got rcvd=%0d wr_data=%b exp 8 1", is_d, rcvd, wd);
            end
            done = 1'b1;
            if (is_d) d_miss = 1'b0;
            else      i_miss = 1'b0;
         end
         if (cyc == store_at) begin
            d_st_req  = 1'b1;
            d_st_addr = 16'h00A0;
            d_st_data = 16'hBEEF;
         end
      end
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL fill_timeout d=%0d: got no tag exp tag within 60 cycles", is_d);
      end
      checks++;
      if (issued != 8) begin
         failures++;
         $display("FAIL fill_count d=%0d: got %0d reads exp 8", is_d, issued);
      end
      checks++;
      if (first != exp_first) begin
         failures++;
         $display("FAIL fill_start d=%0d: got first issue cycle %0d exp %0d", is_d, first, exp_first);
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      i_miss = 1'b1; d_miss = 1'b1; d_st_req = 1'b1;
      i_addr = 16'h1111; d_addr = 16'h2222; d_st_addr = 16'h3333; d_st_data = 16'h4444;
      repeat (2) @(negedge clk);
      checks++;
      if ({mem_en, mem_wr, i_busy, d_busy, i_wr_data, d_wr_data, i_wr_tag, d_wr_tag, d_st_done} !== 9'b0) begin
         failures++;
         $display("FAIL reset_flags: got %b exp 0",
                  {mem_en, mem_wr, i_busy, d_busy, i_wr_data, d_wr_data, i_wr_tag, d_wr_tag, d_st_done});
      end
      checks++;
      if ({mem_addr, mem_wdata, i_off, d_off} !== 38'b0) begin
         failures++;
         $display("FAIL reset_vectors: got addr=%h wdata=%h ioff=%0d doff=%0d exp 0",
                  mem_addr, mem_wdata, i_off, d_off);
      end
      i_miss = 1'b0; d_miss = 1'b0; d_st_req = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({mem_en, i_busy, d_busy} !== 3'b0) begin
         failures++;
         $display("FAIL idle_after_reset: got %b exp 000", {mem_en, i_busy, d_busy});
      end
   endtask

   task automatic test_i_fill;
      i_miss = 1'b1; i_addr = 16'h1234;
      #1;
      checks++;
      if (i_busy !== 1'b1) begin
         failures++;
         $display("FAIL i_busy_pending: got %b exp 1", i_busy);
      end
      watch_fill(1'b0, 16'h1234, 1, -1);
      i_addr = 16'h0000;
      @(negedge clk);
      checks++;
      if (i_busy !== 1'b0 || mem_en !== 1'b0) begin
         failures++;
         $display("FAIL i_busy_drop: got busy=%b en=%b exp 0 0", i_busy, mem_en);
      end
   endtask

   task automatic test_d_over_i;
      d_miss = 1'b1; d_addr = 16'h2006;
      i_miss = 1'b1; i_addr = 16'h1234;
      watch_fill(1'b1, 16'h2006, 1, -1);
      watch_fill(1'b0, 16'h1234, 2, -1);
      @(negedge clk);
      checks++;
      if (i_busy !== 1'b0 || d_busy !== 1'b0) begin
         failures++;
         $display("FAIL d_over_i_done: got i=%b d=%b exp 0 0", i_busy, d_busy);
      end
   endtask

   task automatic test_store_waits;
      i_miss = 1'b1; i_addr = 16'h0550;
      watch_fill(1'b0, 16'h0550, 1, 2);
      @(negedge clk);
      checks++;
      if (mem_en !== 1'b0 || d_st_done !== 1'b0 || d_busy !== 1'b1) begin
         failures++;
         $display("FAIL store_arb_gap: got en=%b done=%b busy=%b exp 0 0 1", mem_en, d_st_done, d_busy);
      end
      @(negedge clk);
      d_st_addr = 16'hFFFF; d_st_data = 16'h0000;
      #1;
      checks++;
      if (mem_en !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 16'h00A0 ||
          mem_wdata !== 16'hBEEF || d_st_done !== 1'b1) begin
         failures++;
         $display("FAIL store_issue: got en=%b wr=%b addr=%h data=%h done=%b exp 1 1 00a0 beef 1",
                  mem_en, mem_wr, mem_addr, mem_wdata, d_st_done);
      end
      d_st_req = 1'b0;
      @(negedge clk);
      checks++;
      if (d_busy !== 1'b0 || d_st_done !== 1'b0 || mem_en !== 1'b0) begin
         failures++;
         $display("FAIL store_after: got busy=%b done=%b en=%b exp 0 0 0", d_busy, d_st_done, mem_en);
      end
   endtask

   task automatic test_back_to_back;
      d_st_req = 1'b1; d_st_addr = 16'h0100; d_st_data = 16'h1234;
      d_miss = 1'b1; d_addr = 16'h3000;
      @(negedge clk);
      checks++;
      if (mem_wr !== 1'b1 || mem_addr !== 16'h0100 || mem_wdata !== 16'h1234 ||
          d_st_done !== 1'b1 || d_busy !== 1'b1) begin
         failures++;
         $display("FAIL b2b_store: got wr=%b addr=%h data=%h done=%b busy=%b exp 1 0100 1234 1 1",
                  mem_wr, mem_addr, mem_wdata, d_st_done, d_busy);
      end
      d_st_req = 1'b0;
      watch_fill(1'b1, 16'h3000, 2, -1);
      @(negedge clk);
      checks++;
      if (d_busy !== 1'b0) begin
         failures++;
         $display("FAIL b2b_busy_drop: got %b exp 0", d_busy);
      end
   endtask

   task automatic test_reset_mid_fill;
      int issued, late, cyc;
      issued = 0; late = 0; cyc = 0;
      d_miss = 1'b1; d_addr = 16'h4000;
      while (issued < 3 && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (mem_en === 1'b1) issued++;
      end
      checks++;
      if (issued != 3) begin
         failures++;
         $display("FAIL rst_mid_start: got %0d reads exp 3", issued);
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({mem_en, mem_wr, i_busy, d_busy, i_wr_data, d_wr_data, i_wr_tag, d_wr_tag, d_st_done} !== 9'b0 ||
          {mem_addr, mem_wdata, i_off, d_off} !== 38'b0) begin
         failures++;
         $display("FAIL rst_mid_outputs: got en=%b busy=%b addr=%h doff=%0d exp all 0",
                  mem_en, d_busy, mem_addr, d_off);
      end
      d_miss = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (mem_valid === 1'b1) late++;
         checks++;
         if (d_wr_data !== 1'b0 || d_wr_tag !== 1'b0 || mem_en !== 1'b0) begin
            failures++;
            $display("FAIL rst_late_valid: got wr_data=%b tag=%b en=%b exp 0 0 0", d_wr_data, d_wr_tag, mem_en);
         end
      end
      checks++;
      if (late != 2) begin
         failures++;
         $display("FAIL rst_late_count: got %0d late returns exp 2", late);
      end
      d_miss = 1'b1; d_addr = 16'h4000;
      watch_fill(1'b1, 16'h4000, 1, -1);
   endtask

   task automatic test_spurious_valid;
      @(negedge clk);
      inj = 1'b1;
      #1;
      checks++;
      if (i_wr_data !== 1'b0 || d_wr_data !== 1'b0 || i_off !== 3'd0 || d_off !== 3'd0) begin
         failures++;
         $display("FAIL spurious_valid: got iwd=%b dwd=%b ioff=%0d doff=%0d exp 0 0 0 0",
                  i_wr_data, d_wr_data, i_off, d_off);
      end
      @(posedge clk);
      #1 inj = 1'b0;
      @(negedge clk);
      i_miss = 1'b1; i_addr = 16'hABCE;
      watch_fill(1'b0, 16'hABCE, 1, -1);
   endtask

   initial begin
      test_reset();
      test_i_fill();
      test_d_over_i();
      test_store_waits();
      test_back_to_back();
      test_reset_mid_fill();
      test_spurious_valid();
      repeat (4) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
